// File: rtl/wb_initiator.sv
// wb_initiator: single-outstanding Wishbone B4 pipelined initiator.
//
// Converts a valid/ready command stream into one bus cycle at a time. Each result
// is returned on a valid/ready response stream. A retry termination reissues the
// strobe up to MAX_RETRY times. Further retries are reported as an error.
//
// Optional feature: define WB_INITIATOR_TIMEOUT_EN to build a bus-timeout
// watchdog. It aborts a cycle that receives no termination within TIMEOUT cycles
// and reports the abort with rsp_tmo_o. Without the macro, the initiator waits
// indefinitely and rsp_tmo_o is tied to 0.
//
// Ports:
//   clk_i, rst_n_i                 clock, asynchronous active-low reset
//   cmd_valid_i / cmd_ready_o      command handshake
//   cmd_we_i, cmd_adr_i,
//   cmd_dat_i, cmd_sel_i           command fields (write flag, address, data, selects)
//   rsp_valid_o / rsp_ready_i      response handshake
//   rsp_dat_o, rsp_err_o,
//   rsp_tmo_o                      read data, failure flag, timeout flag
//   wb_cyc_o, wb_stb_o, wb_we_o,
//   wb_adr_o, wb_sel_o, wb_dat_o   Wishbone request outputs
//   wb_dat_i, wb_ack_i, wb_err_i,
//   wb_rty_i, wb_stall_i           Wishbone responder inputs
module wb_initiator #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned MAX_RETRY  = 3,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_we_i,
    input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
    input  logic [31:0]           cmd_dat_i,
    input  logic [3:0]            cmd_sel_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [31:0]           rsp_dat_o,
    output logic                  rsp_err_o,
    output logic                  rsp_tmo_o,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic                  wb_we_o,
    output logic [ADDR_WIDTH-1:0] wb_adr_o,
    output logic [3:0]            wb_sel_o,
    output logic [31:0]           wb_dat_o,
    input  logic [31:0]           wb_dat_i,
    input  logic                  wb_ack_i,
    input  logic                  wb_err_i,
    input  logic                  wb_rty_i,
    input  logic                  wb_stall_i
);

    if (MAX_RETRY > 15 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_range
        $error("wb_initiator: MAX_RETRY or TIMEOUT out of range");
    end

    localparam logic [3:0] MaxRetry = 4'(MAX_RETRY);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

    state_e                state_q, state_d;
    logic [3:0]            retry_q, retry_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  cyc_q, cyc_d;
    logic                  stb_q, stb_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [3:0]            sel_q, sel_d;
    logic [31:0]           dat_q, dat_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [31:0]           rsp_dat_q, rsp_dat_d;
    logic                  rsp_err_q, rsp_err_d;

    // Transfer completion: set by whichever termination ends the cycle
    logic                  handle_term;
    logic                  terminated;
    logic                  enter_req;
    logic                  fin;
    logic                  fin_err;
    logic                  fin_tmo;
    logic [31:0]           fin_dat;

`ifdef WB_INITIATOR_TIMEOUT_EN
    localparam logic [15:0] TmoLast = 16'(TIMEOUT - 1);
    logic [15:0]           tmo_cnt_q, tmo_cnt_d;
    logic                  rsp_tmo_q, rsp_tmo_d;
`endif

    always_comb begin
        state_d     = state_q;
        retry_d     = retry_q;
        cmd_ready_d = cmd_ready_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        we_d        = we_q;
        adr_d       = adr_q;
        sel_d       = sel_q;
        dat_d       = dat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
        handle_term = 1'b0;
        enter_req   = 1'b0;
        fin         = 1'b0;
        fin_err     = 1'b0;
        fin_tmo     = 1'b0;
        fin_dat     = '0;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid_i && cmd_ready_q) begin
                    we_d        = cmd_we_i;
                    adr_d       = cmd_adr_i;
                    dat_d       = cmd_dat_i;
                    sel_d       = cmd_sel_i;
                    cyc_d       = 1'b1;
                    stb_d       = 1'b1;
                    retry_d     = '0;
                    cmd_ready_d = 1'b0;
                    enter_req   = 1'b1;
                    state_d     = StReq;
                end
            end
            StReq: begin
                // Request is taken when stall is low; a termination in that
                // same cycle is processed exactly as in WAIT.
                if (!wb_stall_i) begin
                    stb_d       = 1'b0;
                    state_d     = StWait;
                    handle_term = 1'b1;
                end
            end
            StWait: begin
                handle_term = 1'b1;
            end
            StResp: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        terminated = handle_term && (wb_err_i || wb_ack_i || wb_rty_i);

        if (handle_term) begin
            if (wb_err_i) begin
                fin     = 1'b1;
                fin_err = 1'b1;
            end else if (wb_ack_i) begin
                fin     = 1'b1;
                fin_dat = we_q ? 32'h0 : wb_dat_i;
            end else if (wb_rty_i) begin
                if (retry_q < MaxRetry) begin
                    retry_d   = retry_q + 4'd1;
                    stb_d     = 1'b1;
                    enter_req = 1'b1;
                    state_d   = StReq;
                end else begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end
            end
        end

`ifdef WB_INITIATOR_TIMEOUT_EN
        rsp_tmo_d = rsp_tmo_q;
        tmo_cnt_d = tmo_cnt_q;
        if (enter_req) begin
            tmo_cnt_d = '0;
        end else if (state_q == StReq || state_q == StWait) begin
            tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
        // A termination in the expiry cycle wins over the watchdog
        if ((state_q == StReq || state_q == StWait) && !terminated &&
            tmo_cnt_q == TmoLast) begin
            fin     = 1'b1;
            fin_err = 1'b1;
            fin_tmo = 1'b1;
        end
        if (fin) begin
            rsp_tmo_d = fin_tmo;
        end
`endif

        if (fin) begin
            cyc_d       = 1'b0;
            stb_d       = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_err_d   = fin_err;
            rsp_dat_d   = fin_err ? 32'h0 : fin_dat;
            state_d     = StResp;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= StIdle;
            retry_q     <= '0;
            cmd_ready_q <= 1'b0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            sel_q       <= '0;
            dat_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            retry_q     <= retry_d;
            cmd_ready_q <= (state_d == StIdle) ? 1'b1 : cmd_ready_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            sel_q       <= sel_d;
            dat_q       <= dat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

`ifdef WB_INITIATOR_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tmo_cnt_q <= '0;
            rsp_tmo_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            rsp_tmo_q <= rsp_tmo_d;
        end
    end

    assign rsp_tmo_o = rsp_tmo_q;
`else
    assign rsp_tmo_o = 1'b0;
`endif

    assign cmd_ready_o = cmd_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_dat_o   = rsp_dat_q;
    assign rsp_err_o   = rsp_err_q;
    assign wb_cyc_o    = cyc_q;
    assign wb_stb_o    = stb_q;
    assign wb_we_o     = we_q;
    assign wb_adr_o    = adr_q;
    assign wb_sel_o    = sel_q;
    assign wb_dat_o    = dat_q;

endmodule

// File: tb/tb_wb_initiator.sv
// tb_wb_initiator: self-checking bench for wb_initiator.
// It uses a behavioural Wishbone responder that drives its inputs on the falling edge.
// It also keeps a scoreboard of expected responses.
module tb_wb_initiator;

    localparam int unsigned AW = 32;

    logic          clk;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_we;
    logic [AW-1:0] cmd_adr;
    logic [31:0]   cmd_dat;
    logic [3:0]    cmd_sel;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_dat;
    logic          rsp_err;
    logic          rsp_tmo;
    logic          wb_cyc;
    logic          wb_stb;
    logic          wb_we;
    logic [AW-1:0] wb_adr;
    logic [3:0]    wb_sel;
    logic [31:0]   wb_dato;
    logic [31:0]   wb_dati;
    logic          wb_ack;
    logic          wb_err;
    logic          wb_rty;
    logic          wb_stall;

    wb_initiator #(
        .ADDR_WIDTH(AW),
        .MAX_RETRY (3),
        .TIMEOUT   (8)
    ) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .cmd_valid_i(cmd_valid),
        .cmd_ready_o(cmd_ready),
        .cmd_we_i   (cmd_we),
        .cmd_adr_i  (cmd_adr),
        .cmd_dat_i  (cmd_dat),
        .cmd_sel_i  (cmd_sel),
        .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready),
        .rsp_dat_o  (rsp_dat),
        .rsp_err_o  (rsp_err),
        .rsp_tmo_o  (rsp_tmo),
        .wb_cyc_o   (wb_cyc),
        .wb_stb_o   (wb_stb),
        .wb_we_o    (wb_we),
        .wb_adr_o   (wb_adr),
        .wb_sel_o   (wb_sel),
        .wb_dat_o   (wb_dato),
        .wb_dat_i   (wb_dati),
        .wb_ack_i   (wb_ack),
        .wb_err_i   (wb_err),
        .wb_rty_i   (wb_rty),
        .wb_stall_i (wb_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] dat;
        logic        err;
        logic        tmo;
    } rsp_t;
    rsp_t sb[$];

    // Responder configuration: mode 0 = ack, 1 = err, 2 = silent, 3 = ack on cyc cycle ack_at
    int            mode = 0;
    int            stall_left = 0;
    int            rty_left = 0;
    int            ack_at = 0;
    logic [31:0]   rdata = 32'h0;
    logic          late_ack = 1'b0;
    logic          check_fields = 1'b0;
    logic [AW-1:0] exp_adr = '0;
    logic [31:0]   exp_wdat = '0;
    logic [3:0]    exp_sel = '0;
    // Observations
    int            stb_cycles = 0;
    int            phases = 0;
    int            cyc_cycles = 0;
    int            cyc_rises = 0;
    int            bad_fields = 0;
    logic          cyc_prev = 1'b0;

    always @(negedge clk) begin
        wb_ack   = 1'b0;
        wb_err   = 1'b0;
        wb_rty   = 1'b0;
        wb_stall = 1'b0;
        wb_dati  = 32'hDEADBEEF;
        if (wb_cyc) begin
            cyc_cycles++;
            if (!cyc_prev) cyc_rises++;
        end
        cyc_prev = wb_cyc;
        if (wb_cyc && wb_stb) begin
            stb_cycles++;
            if (check_fields && (wb_adr !== exp_adr || wb_dato !== exp_wdat ||
                                 wb_sel !== exp_sel || wb_we !== 1'b1))
                bad_fields++;
            if (stall_left > 0) begin
                wb_stall = 1'b1;
                stall_left--;
            end else begin
                phases++;
                if (rty_left > 0) begin
                    wb_rty = 1'b1;
                    rty_left--;
                end else if (mode == 0) begin
                    wb_ack  = 1'b1;
                    wb_dati = rdata;
                end else if (mode == 1) begin
                    wb_err  = 1'b1;
                    wb_dati = rdata;
                end
            end
        end
        if (mode == 3 && wb_cyc && cyc_cycles == ack_at) begin
            wb_ack  = 1'b1;
            wb_dati = rdata;
        end
        if (late_ack) begin
            wb_ack  = 1'b1;
            wb_dati = 32'h0BADF00D;
        end
    end

    task automatic clear_obs();
        stb_cycles = 0;
        phases     = 0;
        cyc_cycles = 0;
        cyc_rises  = 0;
        bad_fields = 0;
    endtask

    // Returns at accept edge + 1
    task automatic send_cmd(input logic we, input logic [AW-1:0] adr,
                            input logic [31:0] dat, input logic [3:0] sel);
        int n = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = sel;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            checks++;
            failures++;
            $display("FAIL cmd_accept_timeout got cmd_ready=%b exp=1", cmd_ready);
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    // Waits (bounded) for a response and consumes it
    task automatic get_rsp(output logic [31:0] d, output logic e, output logic t);
        int n = 0;
        while (!rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) begin
            checks++;
            failures++;
            $display("FAIL rsp_wait_timeout got rsp_valid=%b exp=1", rsp_valid);
        end
        d = rsp_dat;
        e = rsp_err;
        t = rsp_tmo;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_adr   = '0;
        cmd_dat   = '0;
        cmd_sel   = '0;
        rsp_ready = 1'b0;
        #12;
        checks++;
        if ({cmd_ready, rsp_valid, rsp_err, rsp_tmo, wb_cyc, wb_stb, wb_we} !== 7'b0 ||
            rsp_dat !== 32'h0 || wb_adr !== '0 || wb_dato !== 32'h0 || wb_sel !== 4'h0) begin
            failures++;
            $display("FAIL reset_outputs got rdy=%b rv=%b cyc=%b stb=%b exp all 0",
                     cmd_ready, rsp_valid, wb_cyc, wb_stb);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%b exp=1", cmd_ready);
        end
    endtask

    task automatic test_read();
        logic [31:0] d;
        logic        e;
        logic        t;
        rsp_t        x;
        clear_obs();
        mode  = 0;
        rdata = 32'hCAFEF00D;
        sb.push_back('{dat: 32'hCAFEF00D, err: 1'b0, tmo: 1'b0});
        send_cmd(1'b0, 32'h10, 32'h0, 4'hF);
        @(negedge clk);
        checks++;
        if ({wb_cyc, wb_stb, rsp_valid} !== 3'b110) begin
            failures++;
            $display("FAIL read_n1 got cyc/stb/rv=%b exp=110", {wb_cyc, wb_stb, rsp_valid});
        end
        @(negedge clk);
        checks++;
        if ({wb_cyc, wb_stb, rsp_valid} !== 3'b001) begin
            failures++;
            $display("FAIL read_n2 got cyc/stb/rv=%b exp=001", {wb_cyc, wb_stb, rsp_valid});
        end
        get_rsp(d, e, t);
        x = sb.pop_front();
        checks++;
        if ({d, e, t} !== {x.dat, x.err, x.tmo}) begin
            failures++;
            $display("FAIL read_rsp got dat=%h err=%b tmo=%b exp dat=%h err=%b tmo=%b",
                     d, e, t, x.dat, x.err, x.tmo);
        end
        checks++;
        if (stb_cycles != 1 || cyc_cycles != 1) begin
            failures++;
            $display("FAIL read_pulse got stb=%0d cyc=%0d exp 1 1", stb_cycles, cyc_cycles);
        end
    endtask

    task automatic test_write_stall();
        logic [31:0] d;
        logic        e;
        logic        t;
        rsp_t        x;
        clear_obs();
        mode         = 0;
        rdata        = 32'h55AA55AA;
        stall_left   = 3;
        exp_adr      = 32'h4;
        exp_wdat     = 32'h000000F0;
        exp_sel      = 4'hF;
        check_fields = 1'b1;
        sb.push_back('{dat: 32'h0, err: 1'b0, tmo: 1'b0});
        send_cmd(1'b1, 32'h4, 32'h000000F0, 4'hF);
        get_rsp(d, e, t);
        check_fields = 1'b0;
        x = sb.pop_front();
        checks++;
        if ({d, e, t} !== {x.dat, x.err, x.tmo}) begin
            failures++;
            $display("FAIL write_rsp got dat=%h err=%b tmo=%b exp dat=%h err=%b tmo=%b",
                     d, e, t, x.dat, x.err, x.tmo);
        end
        checks++;
        if (stb_cycles != 4 || bad_fields != 0) begin
            failures++;
            $display("FAIL write_stall got stb=%0d bad=%0d exp 4 0", stb_cycles, bad_fields);
        end
    endtask

    task automatic test_retry();
        logic [31:0] d;
        logic        e;
        logic        t;
        rsp_t        x;
        // Two retries then ack
        clear_obs();
        mode     = 0;
        rdata    = 32'h12340001;
        rty_left = 2;
        sb.push_back('{dat: 32'h12340001, err: 1'b0, tmo: 1'b0});
        send_cmd(1'b0, 32'h20, 32'h0, 4'hF);
        get_rsp(d, e, t);
        x = sb.pop_front();
        checks++;
        if ({d, e, t} !== {x.dat, x.err, x.tmo}) begin
            failures++;
            $display("FAIL retry_ok_rsp got dat=%h err=%b tmo=%b exp dat=%h err=%b",
                     d, e, t, x.dat, x.err);
        end
        checks++;
        if (phases != 3 || cyc_rises != 1) begin
            failures++;
            $display("FAIL retry_ok_phases got phases=%0d cycs=%0d exp 3 1", phases, cyc_rises);
        end
        // Retry forever
        clear_obs();
        rty_left = 100;
        sb.push_back('{dat: 32'h0, err: 1'b1, tmo: 1'b0});
        send_cmd(1'b0, 32'h24, 32'h0, 4'hF);
        get_rsp(d, e, t);
        rty_left = 0;
        x = sb.pop_front();
        checks++;
        if ({d, e, t} !== {x.dat, x.err, x.tmo}) begin
            failures++;
            $display("FAIL retry_exh_rsp got dat=%h err=%b tmo=%b exp dat=%h err=%b",
                     d, e, t, x.dat, x.err);
        end
        checks++;
        if (phases != 4 || cyc_rises != 1) begin
            failures++;
            $display("FAIL retry_exh_phases got phases=%0d cycs=%0d exp 4 1", phases, cyc_rises);
        end
    endtask

    task automatic test_err_hold();
        logic [31:0] d;
        logic        e;
        logic        t;
        rsp_t        x;
        int          bad = 0;
        clear_obs();
        mode  = 1;
        rdata = 32'hFFFF0000;
        sb.push_back('{dat: 32'h0, err: 1'b1, tmo: 1'b0});
        send_cmd(1'b0, 32'h30, 32'h0, 4'h3);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_dat !== 32'h0 ||
                cmd_ready !== 1'b0)
                bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL rsp_hold got unstable cycles=%0d exp 0", bad);
        end
        get_rsp(d, e, t);
        mode = 0;
        x = sb.pop_front();
        checks++;
        if ({d, e, t} !== {x.dat, x.err, x.tmo}) begin
            failures++;
            $display("FAIL err_rsp got dat=%h err=%b tmo=%b exp dat=%h err=%b",
                     d, e, t, x.dat, x.err);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic        e;
        logic        t;
        rsp_t        x;
        for (int i = 0; i < 3; i++) begin
            mode  = 0;
            rdata = 32'hA5000000 + 32'(i * 17);
            if (i == 1) begin
                sb.push_back('{dat: 32'h0, err: 1'b0, tmo: 1'b0});
                send_cmd(1'b1, 32'(i * 4), 32'h1111 * 32'(i), 4'h1);
            end else begin
                sb.push_back('{dat: 32'hA5000000 + 32'(i * 17), err: 1'b0, tmo: 1'b0});
                send_cmd(1'b0, 32'(i * 4), 32'h0, 4'hF);
            end
            get_rsp(d, e, t);
            checks++;
            if (cmd_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b_ready[%0d] got=%b exp=1", i, cmd_ready);
            end
            x = sb.pop_front();
            checks++;
            if ({d, e, t} !== {x.dat, x.err, x.tmo}) begin
                failures++;
                $display("FAIL b2b_rsp[%0d] got dat=%h err=%b exp dat=%h err=%b",
                         i, d, e, x.dat, x.err);
            end
        end
    endtask

`ifdef WB_INITIATOR_TIMEOUT_EN
    task automatic test_timeout();
        logic [31:0] d;
        logic        e;
        logic        t;
        rsp_t        x;
        clear_obs();
        mode = 2;
        sb.push_back('{dat: 32'h0, err: 1'b1, tmo: 1'b1});
        send_cmd(1'b0, 32'h40, 32'h0, 4'hF);
        get_rsp(d, e, t);
        x = sb.pop_front();
        checks++;
        if ({d, e, t} !== {x.dat, x.err, x.tmo}) begin
            failures++;
            $display("FAIL tmo_rsp got dat=%h err=%b tmo=%b exp dat=%h err=%b tmo=%b",
                     d, e, t, x.dat, x.err, x.tmo);
        end
        checks++;
        if (cyc_cycles != 8) begin
            failures++;
            $display("FAIL tmo_cyc_len got=%0d exp=8", cyc_cycles);
        end
        late_ack = 1'b1;
        repeat (2) @(negedge clk);
        late_ack = 1'b0;
        @(negedge clk);
        checks++;
        if ({rsp_valid, wb_cyc, cmd_ready} !== 3'b001) begin
            failures++;
            $display("FAIL tmo_late_ack got rv/cyc/rdy=%b exp=001",
                     {rsp_valid, wb_cyc, cmd_ready});
        end
        // Ack on the expiry cycle wins
        clear_obs();
        mode   = 3;
        ack_at = 8;
        rdata  = 32'h87654321;
        sb.push_back('{dat: 32'h87654321, err: 1'b0, tmo: 1'b0});
        send_cmd(1'b0, 32'h44, 32'h0, 4'hF);
        get_rsp(d, e, t);
        mode = 0;
        x = sb.pop_front();
        checks++;
        if ({d, e, t} !== {x.dat, x.err, x.tmo} || cyc_cycles != 8) begin
            failures++;
            $display("FAIL tmo_edge_ack got dat=%h err=%b tmo=%b cyc=%0d exp dat=%h 0 0 8",
                     d, e, t, cyc_cycles, x.dat);
        end
    endtask
`endif

    task automatic test_reset_mid();
        logic [31:0] d;
        logic        e;
        logic        t;
        rsp_t        x;
        clear_obs();
        mode = 2;
        sb.push_back('{dat: 32'h0, err: 1'b0, tmo: 1'b0});
        send_cmd(1'b1, 32'h50, 32'h77, 4'hF);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({wb_cyc, wb_stb, rsp_valid, cmd_ready, wb_we, rsp_err} !== 6'b0 ||
            wb_adr !== '0 || wb_dato !== 32'h0) begin
            failures++;
            $display("FAIL mid_reset got cyc=%b stb=%b rv=%b rdy=%b adr=%h exp all 0",
                     wb_cyc, wb_stb, rsp_valid, cmd_ready, wb_adr);
        end
        void'(sb.pop_front());
        mode = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_norsp got rv=%b exp=0", rsp_valid);
        end
        clear_obs();
        rdata = 32'h600DF00D;
        sb.push_back('{dat: 32'h600DF00D, err: 1'b0, tmo: 1'b0});
        send_cmd(1'b0, 32'h54, 32'h0, 4'hF);
        get_rsp(d, e, t);
        x = sb.pop_front();
        checks++;
        if ({d, e, t} !== {x.dat, x.err, x.tmo}) begin
            failures++;
            $display("FAIL post_reset_rsp got dat=%h err=%b exp dat=%h err=%b",
                     d, e, x.dat, x.err);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_stall();
        test_retry();
        test_err_hold();
        test_back_to_back();
`ifdef WB_INITIATOR_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running exp finished");
        $fatal(1, "global time limit");
    end

endmodule
